// File: rtl/spread_pkg.sv
// Shared types and defaults for the spread engine.
package spread_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int FRAC_BITS   = 16;
  localparam int NUM_SYMBOLS = 4;
  localparam int SYM_W       = $clog2(NUM_SYMBOLS);

  typedef enum logic {
    CFG_GAMMA = 1'b0,
    CFG_LOG   = 1'b1
  } cfg_sel_e;

  // One pipeline stage: the meaning of data changes per stage
  // (tau in S1, gamma*var in S2, p1*tau in S3).
  typedef struct packed {
    logic                  valid;
    logic [SYM_W-1:0]      symbol;
    logic                  sat;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] log_term;
  } stage_t;

endpackage

// File: rtl/sat_mul.sv
// Unsigned W x W multiply, right-shifted by SHIFT, clamped to all-ones on overflow.
module sat_mul #(
  parameter int W     = 32,
  parameter int SHIFT = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  output logic         ovf
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] shifted;

  assign prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign shifted = prod >> SHIFT;
  assign ovf     = |shifted[2*W-1:W];
  assign p       = ovf ? '1 : shifted[W-1:0];

endmodule

// File: rtl/spread_pipe.sv
// Four-stage multi-symbol Avellaneda-Stoikov spread:
//   spread = gamma[s]*var*(T - t) + log_term[s], saturating, with valid/ready.
module spread_pipe
  import spread_pkg::*;
#(
  parameter int                          DATA_WIDTH    = spread_pkg::DATA_WIDTH,
  parameter int                          FRAC_BITS     = spread_pkg::FRAC_BITS,
  parameter int                          NUM_SYMBOLS   = spread_pkg::NUM_SYMBOLS,
  parameter int                          TERMINAL_TIME = 10000,
  parameter logic [DATA_WIDTH-1:0]       DEFAULT_GAMMA = 'h199A,
  parameter logic [DATA_WIDTH-1:0]       DEFAULT_LOG   = 'h20000,
  localparam int                         SW            = $clog2(NUM_SYMBOLS),
  localparam int                         DW            = DATA_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [SW-1:0] i_symbol,
  input  logic [DW-1:0] i_curr_time,
  input  logic [DW-1:0] i_volatility,
  input  logic          i_cfg_we,
  input  logic          i_cfg_sel,
  input  logic [SW-1:0] i_cfg_symbol,
  input  logic [DW-1:0] i_cfg_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [SW-1:0] o_symbol,
  output logic [DW-1:0] o_spread,
  output logic          o_saturated
);

  localparam logic [DW-1:0] T_END = DW'(TERMINAL_TIME);

  logic [DW-1:0] gamma_q [NUM_SYMBOLS];
  logic [DW-1:0] log_q   [NUM_SYMBOLS];

  stage_t        s1, s2, s3;
  logic [DW-1:0] s1_gamma, s1_var, s2_tau;
  logic [DW-1:0] tau_d, p1, p2;
  logic          p1_ovf, p2_ovf;
  logic [DW:0]   sum;
  logic          out_sat;
  logic          adv;

  // Whole pipe moves together; the output register frees up when consumed.
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  // Remaining time, clamped at zero once the session end is reached.
  assign tau_d = (i_curr_time >= T_END) ? '0 : T_END - i_curr_time;

  // Config regfile: writes land on the edge regardless of stall; S1 samples
  // the pre-edge value, so a same-cycle accept sees the old setting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_SYMBOLS; k++) begin
        gamma_q[k] <= DEFAULT_GAMMA;
        log_q[k]   <= DEFAULT_LOG;
      end
    end else if (i_cfg_we) begin
      if (cfg_sel_e'(i_cfg_sel) == CFG_GAMMA) gamma_q[i_cfg_symbol] <= i_cfg_data;
      else                                    log_q[i_cfg_symbol]   <= i_cfg_data;
    end
  end

  // S1: capture the transaction, its tau and the symbol's coefficients.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1       <= '0;
      s1_gamma <= '0;
      s1_var   <= '0;
    end else if (adv) begin
      s1.valid    <= i_valid;
      s1.symbol   <= i_symbol;
      s1.sat      <= 1'b0;
      s1.data     <= tau_d;
      s1.log_term <= log_q[i_symbol];
      s1_gamma    <= gamma_q[i_symbol];
      s1_var      <= i_volatility;
    end
  end

  sat_mul #(.W(DW), .SHIFT(FRAC_BITS)) u_mul_s2 (
    .a   (s1_gamma),
    .b   (s1_var),
    .p   (p1),
    .ovf (p1_ovf)
  );

  // S2: p1 = gamma*var in Q format; tau rides alongside.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s2     <= '0;
      s2_tau <= '0;
    end else if (adv) begin
      s2.valid    <= s1.valid;
      s2.symbol   <= s1.symbol;
      s2.sat      <= s1.sat | p1_ovf;
      s2.data     <= p1;
      s2.log_term <= s1.log_term;
      s2_tau      <= s1.data;
    end
  end

  sat_mul #(.W(DW), .SHIFT(0)) u_mul_s3 (
    .a   (s2.data),
    .b   (s2_tau),
    .p   (p2),
    .ovf (p2_ovf)
  );

  // S3: p2 = p1*tau, tau being a plain integer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s3 <= '0;
    end else if (adv) begin
      s3.valid    <= s2.valid;
      s3.symbol   <= s2.symbol;
      s3.sat      <= s2.sat | p2_ovf;
      s3.data     <= p2;
      s3.log_term <= s2.log_term;
    end
  end

  assign sum     = {1'b0, s3.data} + {1'b0, s3.log_term};
  assign out_sat = s3.sat | sum[DW];

  // S4: add the log term; outputs read as zero while no result is held.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_symbol    <= '0;
      o_spread    <= '0;
      o_saturated <= 1'b0;
    end else if (adv) begin
      o_valid     <= s3.valid;
      o_symbol    <= s3.valid ? s3.symbol : '0;
      o_spread    <= !s3.valid ? '0 : (out_sat ? '1 : sum[DW-1:0]);
      o_saturated <= s3.valid & out_sat;
    end
  end

endmodule

// File: tb/tb_spread_pipe.sv
// Bench for spread_pipe: reference model + scoreboard, directed scenarios.
module tb_spread_pipe;

  localparam int SW = 2;
  localparam int NS = 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b1;
  logic          i_cfg_we = 1'b0;
  logic          i_cfg_sel = 1'b0;
  logic [SW-1:0] i_symbol = '0;
  logic [SW-1:0] i_cfg_symbol = '0;
  logic [31:0]   i_curr_time = '0;
  logic [31:0]   i_volatility = '0;
  logic [31:0]   i_cfg_data = '0;
  logic          o_ready, o_valid, o_saturated;
  logic [SW-1:0] o_symbol;
  logic [31:0]   o_spread;

  int checks = 0;
  int passes = 0;

  always #5 i_clk = ~i_clk;

  spread_pipe dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_symbol     (i_symbol),
    .i_curr_time  (i_curr_time),
    .i_volatility (i_volatility),
    .i_cfg_we     (i_cfg_we),
    .i_cfg_sel    (i_cfg_sel),
    .i_cfg_symbol (i_cfg_symbol),
    .i_cfg_data   (i_cfg_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_symbol     (o_symbol),
    .o_spread     (o_spread),
    .o_saturated  (o_saturated)
  );

  typedef struct packed {
    logic [SW-1:0] sym;
    logic [31:0]   spread;
    logic          sat;
  } res_t;

  logic [31:0] m_gamma [NS];
  logic [31:0] m_log   [NS];
  res_t        exp_q[$];
  res_t        got_q[$];
  res_t        e_res, a_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  // Exact-arithmetic reference: wide integers, clamp wherever a step exceeds 32 bits.
  function automatic res_t model(input logic [SW-1:0] s, input logic [31:0] t,
                                 input logic [31:0] v);
    logic [127:0] p1, p2, tot;
    logic [31:0]  tau;
    logic         sat;
    res_t         r;
    tau = (t >= 32'd10000) ? 32'd0 : 32'd10000 - t;
    p1  = (128'(m_gamma[s]) * 128'(v)) >> 16;
    sat = (p1 > 128'hFFFF_FFFF);
    if (sat) p1 = 128'hFFFF_FFFF;
    p2  = p1 * 128'(tau);
    sat = sat || (p2 > 128'hFFFF_FFFF);
    tot = p2 + 128'(m_log[s]);
    sat = sat || (tot > 128'hFFFF_FFFF);
    r.sym    = s;
    r.spread = sat ? 32'hFFFF_FFFF : tot[31:0];
    r.sat    = sat;
    return r;
  endfunction

  // Scoreboard: record accepts against the model, compare every output transfer.
  always @(posedge i_clk) begin
    if (i_reset) begin
      exp_q.delete();
      for (int k = 0; k < NS; k++) begin
        m_gamma[k] = 32'h199A;
        m_log[k]   = 32'h20000;
      end
    end else begin
      if (o_valid && i_ready) begin
        a_res = '{sym: o_symbol, spread: o_spread, sat: o_saturated};
        got_q.push_back(a_res);
        if (exp_q.size() == 0) chk("unexpected_output", 64'(o_spread), 64'hDEAD_0000_0000);
        else begin
          e_res = exp_q.pop_front();
          chk("out_symbol", 64'(o_symbol), 64'(e_res.sym));
          chk("out_spread", 64'(o_spread), 64'(e_res.spread));
          chk("out_sat", 64'(o_saturated), 64'(e_res.sat));
        end
      end
      if (!o_valid) chk("idle_outputs_zero", {31'd0, o_saturated, o_spread}, 64'd0);
      if (i_valid && o_ready) exp_q.push_back(model(i_symbol, i_curr_time, i_volatility));
      if (i_cfg_we) begin
        if (i_cfg_sel) m_log[i_cfg_symbol]   = i_cfg_data;
        else           m_gamma[i_cfg_symbol] = i_cfg_data;
      end
    end
  end

  task automatic send(input int sym, input logic [31:0] t, input logic [31:0] v);
    int n = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_symbol = SW'(sym); i_curr_time = t; i_volatility = v;
    #1;
    while (!o_ready && n < 50) begin
      @(negedge i_clk); #1; n++;
    end
    if (n >= 50) chk("send_timeout", 64'd0, 64'd1);
    @(posedge i_clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge i_clk);
    i_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge i_clk); n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic cfg(input logic sel, input int sym, input logic [31:0] d);
    @(negedge i_clk);
    i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_symbol = SW'(sym); i_cfg_data = d;
    @(negedge i_clk);
    i_cfg_we = 1'b0;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [31:0] sp,
                         input logic sat);
    if (got_q.size() <= idx) chk({name, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
    else begin
      chk({name, "_spread"}, 64'(got_q[idx].spread), 64'(sp));
      chk({name, "_sat"}, 64'(got_q[idx].sat), 64'(sat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    #1;
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_spread", 64'(o_spread), 64'd0);
    chk("reset_o_saturated", 64'(o_saturated), 64'd0);
    chk("reset_o_symbol", 64'(o_symbol), 64'd0);
    chk("reset_o_ready", 64'(o_ready), 64'd1);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;

    // 1) defaults, latency
    got_q.delete();
    send(0, 32'd9990, 32'h10000);
    repeat (3) begin
      @(negedge i_clk); i_valid = 1'b0;
      chk("t1_not_yet_valid", 64'(o_valid), 64'd0);
    end
    @(negedge i_clk);
    chk("t1_valid_at_4", 64'(o_valid), 64'd1);
    drain();
    chk_got("t1", 0, 32'h30004, 1'b0);

    // 2) terminal time and past it
    got_q.delete();
    send(0, 32'd10000, 32'h10000);
    send(0, 32'd12345, 32'hABCDEF);
    drain();
    chk_got("t2_at_T", 0, 32'h20000, 1'b0);
    chk_got("t2_past_T", 1, 32'h20000, 1'b0);

    // 3) saturation
    got_q.delete();
    cfg(1'b0, 0, 32'h10000);
    send(0, 32'd0, 32'hFFFF_FFFF);
    drain();
    chk_got("t3", 0, 32'hFFFF_FFFF, 1'b1);
    cfg(1'b0, 0, 32'h199A);

    // 4) burst of 8 with a 3-cycle downstream stall
    got_q.delete();
    fork
      for (int i = 0; i < 8; i++) send(i % 4, 32'd9990 - 32'(i * 7), 32'h10000 + 32'(i * 32'h1000));
      begin
        repeat (6) @(negedge i_clk);
        i_ready = 1'b0;
        repeat (3) begin
          #1;
          chk("t4_stall_valid", 64'(o_valid), 64'd1);
          chk("t4_stall_ready", 64'(o_ready), 64'd0);
          @(negedge i_clk);
        end
        i_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", 64'(got_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) chk("t4_order", 64'(got_q[i].sym), 64'(i % 4));
    chk_got("t4_first", 0, 32'h30004, 1'b0);

    // 5) config write racing an accept on the same symbol
    got_q.delete();
    @(negedge i_clk);
    i_valid = 1'b1; i_symbol = 2'd2; i_curr_time = 32'd9990; i_volatility = 32'h10000;
    i_cfg_we = 1'b1; i_cfg_sel = 1'b0; i_cfg_symbol = 2'd2; i_cfg_data = 32'h20000;
    #1 chk("t5_ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_cfg_we = 1'b0;
    @(negedge i_clk);
    i_symbol = 2'd1;
    drain();
    chk_got("t5_old_gamma", 0, 32'h30004, 1'b0);
    chk_got("t5_new_gamma", 1, 32'h160000, 1'b0);
    chk_got("t5_sym1", 2, 32'h30004, 1'b0);

    // 6) reset with transactions in flight
    got_q.delete();
    for (int i = 0; i < 5; i++) send(2, 32'd9990, 32'h10000);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("t6_valid_before_reset", 64'(o_valid), 64'd1);
    i_reset = 1'b1;
    #1;
    chk("t6_valid_drops", 64'(o_valid), 64'd0);
    chk("t6_spread_drops", 64'(o_spread), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    chk("t6_no_stale", 64'(seen), 64'd0);
    got_q.delete();
    send(2, 32'd9990, 32'h10000);
    drain();
    chk_got("t6_default_gamma", 0, 32'h30004, 1'b0);

    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
